// File: rtl/prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_buffer: instruction fetch issue plus circular {cmd,pc} queue |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prefetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stop,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_command,
  output logic [XLEN-1:0] out_pc
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0]    DEPTH_W = (AW+2)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] cmd_q [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pending;
  logic            drop;

  logic [AW+1:0]   inflight;
  logic            grant;
  logic            push;
  logic            pop;
  logic            full;
  logic            unused_pc_bits;

  // Credit counts the outstanding fetch so a response always finds a free slot.
  assign inflight = {1'b0, count} + {{(AW+1){1'b0}}, pending};
  assign full     = (count == DEPTH_C);
  assign mem_req  = !reset && !stop && !redirect && (inflight < DEPTH_W);
  assign mem_addr = {fetch_pc[XLEN-1:2], 2'b00};
  assign grant    = mem_req && mem_gnt;

  assign push      = mem_rvalid && pending && !drop && !redirect && !full;
  assign out_valid = (count != '0) && !redirect && !stop;
  assign pop       = out_valid && out_ready;

  assign out_command = (count != '0) ? cmd_q[rd_ptr] : '0;
  assign out_pc      = (count != '0) ? pc_q[rd_ptr]  : '0;

  assign unused_pc_bits = ^{redirect_pc[1:0], fetch_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      drop       <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (grant) begin
        fetch_pc <= mem_addr + XLEN'(4);
      end

      if (grant) begin
        pending    <= 1'b1;
        pending_pc <= mem_addr;
      end else if (mem_rvalid) begin
        pending <= 1'b0;
      end

      // A response arriving with the redirect is discarded directly; only a
      // still-outstanding one needs the drop flag.
      if (redirect) begin
        drop <= pending && !mem_rvalid;
      end else if (mem_rvalid) begin
        drop <= 1'b0;
      end

      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]  <= pending_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// Directed bench for prefetch_buffer: a one-cycle-latency memory model feeds
// the queue and each task checks one behaviour against hand-derived values.
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_command;
  logic [31:0] out_pc;

  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic        rv_inject = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  prefetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stop(stop), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_command(out_command),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cmd_of(input logic [31:0] a);
    return a + 32'h1357_0000;
  endfunction

  // Memory answers every grant exactly one cycle later.
  always @(posedge clk) begin
    rv_q <= mem_req & mem_gnt;
    rd_q <= cmd_of(mem_addr);
  end
  assign mem_rvalid = rv_q | rv_inject;
  assign mem_rdata  = rd_q;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; stop = 1'b0; redirect = 1'b0; mem_gnt = 1'b0;
    out_ready = 1'b0; rv_inject = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    mem_gnt = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if (out_command !== 32'h0) begin miscompares++; $display("FAIL reset_out_command got %h exp 0", out_command); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    step;
  endtask

  task automatic test_streaming;
    do_reset;
    mem_gnt = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*k)) begin miscompares++; $display("FAIL stream_issue c%0d got req=%b addr=%h exp req=1 addr=%h", k, mem_req, mem_addr, 32'(4*k)); end
      if (k < 2) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_latency c%0d got valid=%b exp 0", k, out_valid); end
      end else begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4*(k-2)) || out_command !== cmd_of(32'(4*(k-2)))) begin
          miscompares++; $display("FAIL stream_out c%0d got v=%b pc=%h cmd=%h exp v=1 pc=%h cmd=%h", k, out_valid, out_pc, out_command, 32'(4*(k-2)), cmd_of(32'(4*(k-2))));
        end
      end
      step;
    end
  endtask

  task automatic test_fill;
    int grants;
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'd0; exp_pc[1] = 32'd4; exp_pc[2] = 32'd8; exp_pc[3] = 32'd12; exp_pc[4] = 32'd16;
    do_reset;
    grants = 0;
    mem_gnt = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) grants++;
      step;
    end
    @(negedge clk);
    vectors++; if (grants !== 4) begin miscompares++; $display("FAIL fill_grants got %0d exp 4", grants); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fill_full_req got %b exp 0", mem_req); end
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin miscompares++; $display("FAIL fill_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    step;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_command !== cmd_of(exp_pc[i])) begin
        miscompares++; $display("FAIL fill_drain%0d got v=%b pc=%h cmd=%h exp pc=%h", i, out_valid, out_pc, out_command, exp_pc[i]);
      end
      if (i == 0) begin
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fill_credit_registered got %b exp 0", mem_req); end
      end
      if (i == 1) begin
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'd16) begin miscompares++; $display("FAIL fill_resume got req=%b addr=%h exp req=1 addr=10", mem_req, mem_addr); end
      end
      step;
    end
  endtask

  task automatic test_redirect;
    do_reset;
    mem_gnt = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) step;
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_block got req=%b v=%b exp 0 0", mem_req, out_valid); end
    step;
    redirect = 1'b0;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_target got req=%b addr=%h exp req=1 addr=100", mem_req, mem_addr); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush got v=%b exp 0", out_valid); end
    step;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_no_stale got v=%b pc=%h exp v=0", out_valid, out_pc); end
    step;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_command !== cmd_of(32'h100)) begin
      miscompares++; $display("FAIL redir_first got v=%b pc=%h cmd=%h exp pc=100", out_valid, out_pc, out_command);
    end
    step;
  endtask

  task automatic test_stop;
    do_reset;
    mem_gnt = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step;
    mem_gnt = 1'b0; stop = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stop_freeze c%0d got v=%b req=%b exp 0 0", k, out_valid, mem_req); end
      step;
    end
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_command !== cmd_of(32'(4*i))) begin
        miscompares++; $display("FAIL stop_order%0d got v=%b pc=%h cmd=%h exp pc=%h", i, out_valid, out_pc, out_command, 32'(4*i));
      end
      step;
    end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stop_count got v=%b exp 0 after 3 pops", out_valid); end
    step;
  endtask

  task automatic test_wrap;
    int grants;
    int pops;
    do_reset;
    grants = 0; pops = 0;
    for (int c = 0; c < 60; c++) begin
      mem_gnt = (grants < 9);
      out_ready = c[0];
      @(negedge clk);
      if (mem_req && mem_gnt) grants++;
      if (out_valid && out_ready) begin
        vectors++; if (out_pc !== 32'(4*pops) || out_command !== cmd_of(32'(4*pops))) begin
          miscompares++; $display("FAIL wrap_pop%0d got pc=%h cmd=%h exp pc=%h", pops, out_pc, out_command, 32'(4*pops));
        end
        pops++;
      end
      step;
    end
    @(negedge clk);
    vectors++; if (pops !== 9 || grants !== 9) begin miscompares++; $display("FAIL wrap_total got pops=%0d grants=%0d exp 9 9", pops, grants); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got v=%b exp 0", out_valid); end
    step;
  endtask

  task automatic test_async_reset;
    do_reset;
    mem_gnt = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step;
    #2;
    vectors++; if (out_valid !== 1'b1 || mem_req !== 1'b1) begin miscompares++; $display("FAIL arst_pre got v=%b req=%b exp 1 1", out_valid, mem_req); end
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || out_pc !== 32'h0) begin
      miscompares++; $display("FAIL arst_immediate got v=%b req=%b pc=%h exp 0 0 0", out_valid, mem_req, out_pc);
    end
    step;
    reset = 1'b0; mem_gnt = 1'b0; rv_inject = 1'b1;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL arst_restart got req=%b addr=%h exp 1 0", mem_req, mem_addr); end
    step;
    rv_inject = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_stray_rvalid got v=%b exp 0", out_valid); end
    step;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_fill;
    test_redirect;
    test_stop;
    test_wrap;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
